ir_prefetch_queue: RTL and testbench

//   Parametrised instruction register with a DEPTH-entry prefetch queue between the bus and
//   the control sequencer. Accepts instruction words from the bus, splits each into opcode
//   and operand, and presents them to the sequencer over a valid/ready handshake.

---
 rtl/ir_prefetch_queue.sv | 112 +++++++++++
 tb/tb_ir_prefetch_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ir_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ir_prefetch_queue
// Description : Instruction register fed by a DEPTH-word prefetch queue that
//               assembles one- and two-word instructions for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_prefetch_queue #(
    parameter int              WORD_W  = 8,
    parameter int              OPC_W   = 4,
    parameter int              DEPTH   = 4,
    parameter logic [OPC_W-1:0] EXT_OPC = 4'hF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         load_en,
    input  logic [WORD_W-1:0]            bus_in,
    input  logic                         instr_ready,
    output logic                         instr_valid,
    output logic [OPC_W-1:0]             opcode,
    output logic [WORD_W-1:0]            operand,
    output logic                         is_ext,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH+1);

    logic [WORD_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd;
    logic [c_PTR_W-1:0] r_wr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;

    logic [WORD_W-1:0]  w_head;
    logic [c_PTR_W-1:0] w_rd_next1;
    logic [c_PTR_W-1:0] w_rd_step;
    logic               w_ext;
    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [c_LVL_W-1:0] w_pop_cnt;

    always_comb begin
        w_head     = r_mem[r_rd];
        w_rd_next1 = r_rd + c_PTR_W'(1);
        w_ext      = (w_head[WORD_W-1 -: OPC_W] == EXT_OPC);
        w_full     = (r_level == c_LVL_W'(DEPTH));
        // An ext head needs its operand word present before it is offered
        w_valid    = w_ext ? (r_level >= c_LVL_W'(2)) : (r_level >= c_LVL_W'(1));
        w_rd_step  = w_ext ? c_PTR_W'(2) : c_PTR_W'(1);
        w_pop      = w_valid && instr_ready;
        w_push     = load_en && (!w_full || w_pop);
        w_pop_cnt  = w_pop ? (w_ext ? c_LVL_W'(2) : c_LVL_W'(1)) : '0;
    end

    always_comb begin
        instr_valid = w_valid;
        opcode      = '0;
        operand     = '0;
        is_ext      = 1'b0;
        if (w_valid) begin
            opcode  = w_head[WORD_W-1 -: OPC_W];
            is_ext  = w_ext;
            operand = w_ext ? r_mem[w_rd_next1]
                            : {{OPC_W{1'b0}}, w_head[WORD_W-OPC_W-1:0]};
        end
        full     = w_full;
        empty    = (r_level == '0);
        level    = r_level;
        overflow = r_overflow;
    end

    // Storage needs no reset: contents are only observed through r_level
    always_ff @(negedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr] <= bus_in;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + w_rd_step;
            end
            r_level <= r_level + {{(c_LVL_W-1){1'b0}}, w_push} - w_pop_cnt;
            if (load_en && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ir_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_prefetch_queue
// Description : Directed and random checks of ir_prefetch_queue against a
//               word-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_prefetch_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] bus_in = '0;
    logic       instr_ready = 1'b0;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [7:0] operand;
    logic       is_ext;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_ov = 1'b0;

    ir_prefetch_queue #(.WORD_W(8), .OPC_W(4), .DEPTH(4), .EXT_OPC(4'hF)) dut (
        .clk(clk), .reset(reset), .flush(flush), .load_en(load_en),
        .bus_in(bus_in), .instr_ready(instr_ready), .instr_valid(instr_valid),
        .opcode(opcode), .operand(operand), .is_ext(is_ext), .full(full),
        .empty(empty), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_head_ext();
        return (q.size() > 0) && (q[0][7:4] == 4'hF);
    endfunction

    function automatic bit m_valid();
        if (q.size() == 0) return 1'b0;
        return m_head_ext() ? (q.size() >= 2) : 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [3:0] e_opc = '0;
        logic [7:0] e_opr = '0;
        logic       e_ext = 1'b0;
        if (m_valid()) begin
            e_opc = q[0][7:4];
            e_ext = m_head_ext();
            e_opr = e_ext ? q[1] : {4'h0, q[0][3:0]};
        end
        check_val({tag, ".valid"},   32'(instr_valid), 32'(m_valid()));
        check_val({tag, ".opcode"},  32'(opcode),      32'(e_opc));
        check_val({tag, ".operand"}, 32'(operand),     32'(e_opr));
        check_val({tag, ".is_ext"},  32'(is_ext),      32'(e_ext));
        check_val({tag, ".full"},    32'(full),        32'(q.size() == 4));
        check_val({tag, ".empty"},   32'(empty),       32'(q.size() == 0));
        check_val({tag, ".level"},   32'(level),       32'(q.size()));
        check_val({tag, ".ovf"},     32'(overflow),    32'(m_ov));
    endtask

    task automatic model_step(input bit f, input bit ld, input logic [7:0] d, input bit rdy);
        bit pop;
        bit push;
        if (f) begin
            q.delete();
            m_ov = 1'b0;
        end else begin
            pop  = m_valid() && rdy;
            push = ld && ((q.size() < 4) || pop);
            if (pop) begin
                if (m_head_ext()) void'(q.pop_front());
                void'(q.pop_front());
            end
            if (push) q.push_back(d);
            if (ld && !push) m_ov = 1'b1;
        end
    endtask

    // One falling-edge step: check settled outputs, drive, let the edge happen
    task automatic cycle(input bit f, input bit ld, input logic [7:0] d, input bit rdy);
        @(posedge clk);
        #1;
        check_outputs("pre");
        flush       = f;
        load_en     = ld;
        bus_in      = d;
        instr_ready = rdy;
        @(negedge clk);
        model_step(f, ld, d, rdy);
        #1;
        flush = 1'b0; load_en = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        m_ov = 1'b0;
        check_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // short instruction
        cycle(0, 1, 8'h3A, 1);
        check_val("t1.opcode", 32'(opcode), 32'h3);
        check_val("t1.operand", 32'(operand), 32'h0A);
        cycle(0, 0, 8'h00, 1);
        check_val("t1.empty", 32'(empty), 32'h1);

        // two-word instruction
        cycle(0, 1, 8'hF0, 0);
        check_val("t2.valid_partial", 32'(instr_valid), 32'h0);
        cycle(0, 1, 8'h5C, 0);
        check_val("t2.operand", 32'(operand), 32'h5C);
        check_val("t2.is_ext", 32'(is_ext), 32'h1);
        cycle(0, 0, 8'h00, 1);
        check_val("t2.level", 32'(level), 32'h0);

        // overflow then flush
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h11 * (i + 1)), 0);
        check_val("t3.ovf", 32'(overflow), 32'h1);
        cycle(1, 0, 8'h00, 0);
        check_val("t3.ovf_clr", 32'(overflow), 32'h0);

        // full queue, same-edge push and pop
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'h21 + i), 0);
        cycle(0, 1, 8'h77, 1);
        check_val("t4.level", 32'(level), 32'h4);
        check_val("t4.ovf", 32'(overflow), 32'h0);

        // ext instruction straddling the wrap
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'h41 + i), 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);
        cycle(0, 1, 8'hF7, 0);
        cycle(0, 1, 8'h42, 0);
        check_val("t5.operand", 32'(operand), 32'h42);
        cycle(0, 1, 8'h15, 1);
        check_val("t5.next_opc", 32'(opcode), 32'h1);

        // async reset mid-stream, flush on push edge
        cycle(0, 1, 8'h12, 0);
        cycle(0, 1, 8'h13, 0);
        check_val("t6.level", 32'(level), 32'h3);
        async_reset("t6.async");
        cycle(0, 1, 8'h24, 0);
        cycle(1, 1, 8'h25, 0);
        check_val("t6.flush_push", 32'(level), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[7:4] = 4'hF;
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd.async");
            end else begin
                cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, d,
                      $urandom_range(0, 1) == 1);
            end
        end
        @(posedge clk);
        #1;
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
